acs_trellis_bank: RTL and testbench

Parametrised add-compare-select bank for the Viterbi decoder. It updates all 2^(K-1) path metrics of a rate-1/2 convolutional trellis once per accepted symbol and emits one survivor decision bit per state. It also reports the best (minimum-metric) state and its metric. It sits between the branch-metric unit and the traceback/survivor memory, and replaces per-state ACS instances wired by hand.

---
 rtl/viterbi_pkg.sv | 40 ++++
 rtl/acs_cell.sv | 25 ++
 rtl/acs_trellis_bank.sv | 127 ++++++++++++
 tb/tb_acs_trellis_bank.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// Shared Viterbi helpers: code-bit generation, path-metric compare and the bm array type.
// ACS_NORM_EN selects unsigned compares (normalized metrics); otherwise compares are modulo.
package viterbi_pkg;

    localparam int BM_MAX_W = 16;
    localparam int PM_MAX_W = 32;
    localparam int K_MAX    = 8;

    typedef logic [BM_MAX_W-1:0] bm_arr_t [4];

    function automatic logic parity(input logic [K_MAX-1:0] v);
        return ^v;
    endfunction

    // Code pair {c1,c0} for the transition register {b, p}; p must fit in k-1 bits.
    function automatic logic [1:0] code_pair(input logic b, input logic [K_MAX-1:0] p,
                                             input logic [K_MAX-1:0] g0,
                                             input logic [K_MAX-1:0] g1, input int k);
        logic [K_MAX-1:0] treg;
        treg        = p;
        treg[k-1]   = b;
        return {parity(treg & g1), parity(treg & g0)};
    endfunction

    // a < b on w-bit metrics held zero-extended in PM_MAX_W bits.
    function automatic logic pm_lt(input logic [PM_MAX_W-1:0] a, input logic [PM_MAX_W-1:0] b,
                                   input int w);
        logic [PM_MAX_W-1:0] mask;
        logic [PM_MAX_W-1:0] d;
        mask = (PM_MAX_W'(1) << w) - PM_MAX_W'(1);
`ifdef ACS_NORM_EN
        d = '0;
        return ((a & mask) < (b & mask)) | d[0];
`else
        d = (a - b) & mask;
        return d[w-1];
`endif
    endfunction

endpackage

// File: rtl/acs_cell.sv
// One combinational add-compare-select: two candidate metrics, decision bit, survivor metric.
// Compare semantics follow ACS_NORM_EN through viterbi_pkg::pm_lt.
module acs_cell
    import viterbi_pkg::*;
#(
    parameter int PM_W = 8
) (
    input  logic [PM_W-1:0]     pm_x0,
    input  logic [PM_W-1:0]     pm_x1,
    input  logic [BM_MAX_W-1:0] bm_x0,
    input  logic [BM_MAX_W-1:0] bm_x1,
    output logic [PM_W-1:0]     pm_new,
    output logic                dec
);

    logic [PM_W-1:0] cand0;
    logic [PM_W-1:0] cand1;

    assign cand0  = pm_x0 + PM_W'(bm_x0);
    assign cand1  = pm_x1 + PM_W'(bm_x1);
    // A tie selects predecessor 1.
    assign dec    = !pm_lt(PM_MAX_W'(cand0), PM_MAX_W'(cand1), PM_W);
    assign pm_new = dec ? cand1 : cand0;

endmodule

// File: rtl/acs_trellis_bank.sv
// ACS bank for a rate-1/2 trellis: updates all 2^(K-1) path metrics per accepted symbol,
// emits per-state decisions and the best state/metric. ACS_NORM_EN enables metric normalization.
module acs_trellis_bank
    import viterbi_pkg::*;
#(
    parameter int             K       = 3,
    parameter logic [K-1:0]   G0      = 3'b111,
    parameter logic [K-1:0]   G1      = 3'b101,
    parameter int             BM_W    = 4,
    parameter int             PM_W    = 8,
    parameter logic [PM_W-1:0] INIT_PM = PM_W'(2**(PM_W-2))
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic                  start,
    input  logic [4*BM_W-1:0]     bm,
    output logic                  dec_valid,
    output logic [2**(K-1)-1:0]   dec_vec,
    output logic [K-2:0]          best_state,
    output logic [PM_W-1:0]       best_metric
);

    localparam int NS = 2**(K-1);
    localparam int SW = K-1;

    bm_arr_t         bm_a;
    logic [PM_W-1:0] pm     [NS];
    logic [PM_W-1:0] pm_src [NS];
    logic [PM_W-1:0] pm_new [NS];
    logic [PM_W-1:0] pm_nxt [NS];
    logic [NS-1:0]   dec_w;
    logic [PM_W-1:0] t_m    [1:2*NS-1];
    logic [SW-1:0]   t_i    [1:2*NS-1];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            bm_a[i] = BM_MAX_W'(bm[i*BM_W +: BM_W]);
        end
    end

    // A start symbol decodes against the init profile instead of the registers.
    always_comb begin
        for (int s = 0; s < NS; s++) begin
            if (start) pm_src[s] = (s == 0) ? '0 : INIT_PM;
            else       pm_src[s] = pm[s];
        end
    end

    for (genvar s = 0; s < NS; s++) begin : g_acs
        localparam int       PX0 = (s % (NS/2)) * 2;
        localparam logic     B   = 1'((s >> (K-2)) & 1);
        localparam logic [1:0] CP0 = code_pair(B, K_MAX'(PX0), K_MAX'(G0), K_MAX'(G1), K);
        localparam logic [1:0] CP1 = code_pair(B, K_MAX'(PX0 + 1), K_MAX'(G0), K_MAX'(G1), K);

        acs_cell #(.PM_W(PM_W)) u_acs (
            .pm_x0  (pm_src[PX0]),
            .pm_x1  (pm_src[PX0 + 1]),
            .bm_x0  (bm_a[CP0]),
            .bm_x1  (bm_a[CP1]),
            .pm_new (pm_new[s]),
            .dec    (dec_w[s])
        );
    end

`ifdef ACS_NORM_EN
    localparam logic [PM_W-1:0] HALF = PM_W'(1) << (PM_W-1);
    logic norm;
    // Init-profile symbols start a fresh metric set, so the old best_metric must not shift them.
    assign norm = best_metric[PM_W-1] && !start;
    always_comb begin
        for (int s = 0; s < NS; s++) begin
            pm_nxt[s] = norm ? (pm_new[s] - HALF) : pm_new[s];
        end
    end
`else
    always_comb begin
        for (int s = 0; s < NS; s++) begin
            pm_nxt[s] = pm_new[s];
        end
    end
`endif

    // Min tree: leaves at NS+s; the right child wins only when strictly smaller, keeping the lowest index.
    always_comb begin
        for (int n = 1; n < 2*NS; n++) begin
            t_m[n] = '0;
            t_i[n] = '0;
        end
        for (int s = 0; s < NS; s++) begin
            t_m[NS+s] = pm_nxt[s];
            t_i[NS+s] = SW'(s);
        end
        for (int n = NS-1; n >= 1; n--) begin
            if (pm_lt(PM_MAX_W'(t_m[2*n+1]), PM_MAX_W'(t_m[2*n]), PM_W)) begin
                t_m[n] = t_m[2*n+1];
                t_i[n] = t_i[2*n+1];
            end else begin
                t_m[n] = t_m[2*n];
                t_i[n] = t_i[2*n];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NS; s++) begin
                pm[s] <= (s == 0) ? '0 : INIT_PM;
            end
            dec_valid   <= 1'b0;
            dec_vec     <= '0;
            best_state  <= '0;
            best_metric <= '0;
        end else if (in_valid) begin
            for (int s = 0; s < NS; s++) begin
                pm[s] <= pm_nxt[s];
            end
            dec_valid   <= 1'b1;
            dec_vec     <= dec_w;
            best_state  <= t_i[1];
            best_metric <= t_m[1];
        end else begin
            dec_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_acs_trellis_bank.sv
// Scoreboard bench for acs_trellis_bank (K=3, G0=7, G1=5, BM_W=4, PM_W=8, INIT_PM=64).
// Expected values are hand-derived from the trellis; the long stream uses a tiny metric model.
module tb_acs_trellis_bank;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       start;
    logic [15:0] bm;
    logic       dec_valid;
    logic [3:0] dec_vec;
    logic [1:0] best_state;
    logic [7:0] best_metric;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string      nm;
        logic [3:0] dv;
        logic [1:0] bs;
        logic [7:0] bmet;
    } exp_t;

    exp_t q[$];

    acs_trellis_bank #(
        .K(3), .G0(3'b111), .G1(3'b101), .BM_W(4), .PM_W(8), .INIT_PM(8'd64)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .start       (start),
        .bm          (bm),
        .dec_valid   (dec_valid),
        .dec_vec     (dec_vec),
        .best_state  (best_state),
        .best_metric (best_metric)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    // Monitor: pops one expectation per presented output.
    always @(negedge clk) begin
        if (rst_n && dec_valid) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: got dec_valid=1, required no output");
            end else begin
                exp_t e;
                e = q.pop_front();
                chk({e.nm, ".dec_vec"},     int'(dec_vec),     int'(e.dv));
                chk({e.nm, ".best_state"},  int'(best_state),  int'(e.bs));
                chk({e.nm, ".best_metric"}, int'(best_metric), int'(e.bmet));
            end
        end
    end

    task automatic sym(input logic st, input int b0, input int b1, input int b2, input int b3,
                       input logic [3:0] ed, input logic [1:0] es, input logic [7:0] em,
                       input string nm);
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1;
        start    = st;
        bm       = {4'(b3), 4'(b2), 4'(b1), 4'(b0)};
        e.nm = nm; e.dv = ed; e.bs = es; e.bmet = em;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            start    = 1'b0;
        end
    endtask

    task automatic gap_chk(input int n, input logic [3:0] ed, input logic [1:0] es,
                           input logic [7:0] em);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            start    = 1'b0;
            @(posedge clk);
            #1;
            chk("gap.dec_valid",   int'(dec_valid),   0);
            chk("gap.dec_vec",     int'(dec_vec),     int'(ed));
            chk("gap.best_state",  int'(best_state),  int'(es));
            chk("gap.best_metric", int'(best_metric), int'(em));
        end
    endtask

    task automatic zero_chk(input string nm);
        chk({nm, ".dec_valid"},   int'(dec_valid),   0);
        chk({nm, ".dec_vec"},     int'(dec_vec),     0);
        chk({nm, ".best_state"},  int'(best_state),  0);
        chk({nm, ".best_metric"}, int'(best_metric), 0);
    endtask

    initial begin
        int m;
        logic [3:0] ed;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        start    = 1'b0;
        bm       = '0;
        #3;
        zero_chk("reset");
        #4 rst_n = 1'b1;

        // pm {0,64,64,64} -> {0,66,4,66}; states 1 and 3 tie
        sym(1'b1, 0, 2, 2, 4, 4'b1010, 2'd0, 8'd0, "start_a");
        // -> {0,6,4,6}
        sym(1'b0, 0, 2, 2, 4, 4'b0000, 2'd0, 8'd0, "cont_b");
        // -> {5,4,3,5}
        sym(1'b0, 5, 0, 1, 3, 4'b0000, 2'd2, 8'd3, "cont_c");
        gap_chk(5, 4'b0000, 2'd2, 8'd3);
        // -> {4,12,4,12}; states 0 and 2 share the minimum
        sym(1'b0, 0, 9, 9, 0, 4'b0101, 2'd0, 8'd4, "after_gap");
        sym(1'b1, 0, 2, 2, 4, 4'b1010, 2'd0, 8'd0, "midframe_start");
        sym(1'b1, 0, 2, 2, 4, 4'b1010, 2'd0, 8'd0, "b2b_start");
        // equal bm: {3,67,3,67} -> {6,6,6,6} -> {9,9,9,9}
        sym(1'b1, 3, 3, 3, 3, 4'b1010, 2'd0, 8'd3, "tie1");
        sym(1'b0, 3, 3, 3, 3, 4'b0000, 2'd0, 8'd6, "tie2");
        sym(1'b0, 3, 3, 3, 3, 4'b1111, 2'd0, 8'd9, "tie3");
        idle(2);

        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        zero_chk("rst_mid");
        #3 rst_n = 1'b1;
        sym(1'b0, 0, 2, 2, 4, 4'b1010, 2'd0, 8'd0, "post_reset");

        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b1;
        @(posedge clk);
        #1;
        chk("start_novalid.dec_valid", int'(dec_valid), 0);
        sym(1'b0, 0, 2, 2, 4, 4'b0000, 2'd0, 8'd0, "ignored_start");

        // Constant bm 15: after symbol 2 all metrics are equal, so every state ties.
        m = 0;
        for (int n = 1; n <= 40; n++) begin
            if (n == 1) begin
                ed = 4'b1010;
                m  = 15;
            end else begin
                ed = (n == 2) ? 4'b0000 : 4'b1111;
`ifdef ACS_NORM_EN
                m = m + 15 - ((m >= 128) ? 128 : 0);
`else
                m = (m + 15) % 256;
`endif
            end
            sym(n == 1, 15, 15, 15, 15, ed, 2'd0, 8'(m), "stream");
        end
        idle(3);
        chk("drain.pending", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
